unibus_insync: RTL
==================

Name: unibus_insync

Overview:
- Upstream front end for every Unibus-facing block in the fabric (switch/light/DMA, console, memory).
- Takes raw transceiver-side Unibus inputs and synchronizes them to the 100 MHz CLOCK.
- Filters glitches on the slow control lines (INIT, ACLO, DCLO).
- Produces two versions of MSYN/SSYN:
  - `syn_*`: synchronized only.
  - `del_*`: deskewed, asserted only after the multiplexed address/control/data lines have had time to settle.
- Also counts runt MSYN pulses for diagnostics.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on every raw input (minimum 2).
- DESKEW, 15: CLOCK cycles syn_msyn/syn_ssyn must stay continuously high before del_msyn/del_ssyn assert (150 ns at 100 MHz).
- FILT, 4: consecutive identical samples required before a filtered control output changes.

Ports:
- CLOCK  in  1  system clock, 100 MHz.
- RESET_N  in  1  reset; asynchronous, active-low.
- bus_a_h  in  18  raw address.
- bus_c_h  in  2  raw C1,C0.
- bus_d_h  in  16  raw data.
- bus_msyn_h, bus_ssyn_h, bus_bbsy_h, bus_sack_h, bus_hltrq_h  in  1 each  raw, active-high.
- bus_npg_l, bus_hltgr_l  in  1 each  raw, active-low.
- bus_init_h, bus_aclo_h, bus_dclo_h  in  1 each  raw, active-high.
- a_in_h  out  18  synchronized address.
- c_in_h  out  2  synchronized control.
- d_in_h  out  16  synchronized data.
- syn_msyn_in_h, syn_ssyn_in_h  out  1 each  synchronized strobes.
- del_msyn_in_h, del_ssyn_in_h  out  1 each  deskewed strobes.
- bbsy_in_h, sack_in_h, hltrq_in_h  out  1 each  synchronized.
- npg_in_l, hltgr_in_l  out  1 each  synchronized, active-low.
- init_in_h, ac_lo_in_h, dc_lo_in_h  out  1 each  filtered.
- runtcnt  out  16  saturating count of MSYN runt pulses.
- runtclr  in  1  synchronous clear of runtcnt.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - All sync stages and outputs go to 0, except active-low signals (npg_in_l, hltgr_in_l and their stages), which go to 1.
  - init_in_h, ac_lo_in_h and dc_lo_in_h reset to 1. Downstream therefore sees INIT/power-low asserted until the filters see real bus levels.
  - Deskew counters and filter counters reset to 0.
- Synchronizers:
  - Every raw input passes through SYNC_STAGES flops.
  - Input-to-`syn_*`/`*_in` latency is exactly SYNC_STAGES cycles.
  - Multi-bit a/c/d are not coherent per cycle. Consumers sample them only after a `del_*` strobe.
- Deskew (identical logic for msyn and ssyn), per-strobe counter cnt, width ceil(log2(DESKEW+1)):
  - If syn strobe is 0: cnt <= 0, del <= 0.
  - If syn strobe is 1 and cnt != DESKEW: cnt <= cnt+1.
  - del is registered: del <= (cnt == DESKEW) & syn strobe.
  - Result: del rises DESKEW+1 cycles after syn rises, and falls the cycle after syn falls. Deassertion is never delayed.
  - cnt saturates at DESKEW; there is no wrap.
- Runt detect:
  - A runt is a falling edge of syn_msyn_in_h while cnt_msyn < DESKEW (del_msyn never asserted).
  - A runt increments runtcnt; runtcnt saturates at 16'hFFFF.
  - runtclr has priority over a coincident runt: result is 0.
- Control filters (init, aclo, dclo), each with state STABLE and counting:
  - Output changes only after the synchronized input differs from the output for FILT consecutive cycles. The counter resets whenever the input equals the output.
  - Output latency from a clean raw edge: SYNC_STAGES+FILT cycles.
  - A pulse of FILT-1 cycles or less never propagates.
- Simultaneous MSYN/SSYN activity: the two deskew paths are independent.
- INIT does not reset the deskew logic or runtcnt; only RESET_N does.

Test Plan:
- Reset: drive RESET_N low mid-count with bus_msyn_h=1 -> del_msyn_in_h=0, init_in_h=1, npg_in_l=1, runtcnt=0 immediately (async). After release with bus_init_h=0 -> init_in_h falls at cycle SYNC_STAGES+FILT=6.
- Deskew: raise bus_msyn_h at cycle 0 and hold -> syn_msyn_in_h=1 at cycle 2, del_msyn_in_h=1 at cycle 18. Drop at cycle 40 -> syn=0 at cycle 42, del=0 at cycle 43.
- Runt: 10-cycle MSYN pulse, repeated 3 times -> del_msyn never asserts, runtcnt=3. Pulse runtclr coincident with a 4th runt -> runtcnt=0.
- Saturation: preload via 65537 runts (or force) -> runtcnt holds 16'hFFFF.
- Filter: bus_dclo_h high for 3 cycles -> dc_lo_in_h unchanged. High for 4 cycles -> dc_lo_in_h=1 at edge+6. Same test on ACLO while MSYN deskews concurrently -> no interaction.
- Data path: bus_a_h=18'o777570, bus_d_h=16'o123456, then MSYN -> at del_msyn_in_h rise, a_in_h=777570 and d_in_h=123456. Independent SSYN with DESKEW timing is checked the same way.

Source files
------------

// File: rtl/unibus_insync.sv
// Unibus input front end. Brings the raw transceiver-side Unibus lines into the
// CLOCK domain, deglitches the slow power/init lines, produces deskewed MSYN/SSYN
// strobes that only assert once the multiplexed A/C/D lines have settled, and
// keeps a saturating count of runt MSYN pulses for diagnostics.
module unibus_insync #(
    parameter int unsigned SYNC_STAGES = 2,   // flops per raw input, must be >= 2
    parameter int unsigned DESKEW      = 15,  // cycles a strobe must stay high before del_*
    parameter int unsigned FILT        = 4    // identical samples before a filtered line moves
) (
    input  logic        CLOCK,
    input  logic        RESET_N,

    input  logic [17:0] bus_a_h,
    input  logic [1:0]  bus_c_h,
    input  logic [15:0] bus_d_h,
    input  logic        bus_msyn_h,
    input  logic        bus_ssyn_h,
    input  logic        bus_bbsy_h,
    input  logic        bus_sack_h,
    input  logic        bus_hltrq_h,
    input  logic        bus_npg_l,
    input  logic        bus_hltgr_l,
    input  logic        bus_init_h,
    input  logic        bus_aclo_h,
    input  logic        bus_dclo_h,

    output logic [17:0] a_in_h,
    output logic [1:0]  c_in_h,
    output logic [15:0] d_in_h,
    output logic        syn_msyn_in_h,
    output logic        syn_ssyn_in_h,
    output logic        del_msyn_in_h,
    output logic        del_ssyn_in_h,
    output logic        bbsy_in_h,
    output logic        sack_in_h,
    output logic        hltrq_in_h,
    output logic        npg_in_l,
    output logic        hltgr_in_l,
    output logic        init_in_h,
    output logic        ac_lo_in_h,
    output logic        dc_lo_in_h,

    output logic [15:0] runtcnt,
    input  logic        runtclr
);

    // Lines whose synchronizer stages reset to 0, and lines whose stages reset to 1.
    localparam int unsigned ZW = 41;
    localparam int unsigned OW = 5;

    localparam int unsigned CW = (DESKEW > 0) ? $clog2(DESKEW + 1) : 1;
    localparam int unsigned FW = (FILT > 1) ? $clog2(FILT + 1) : 1;
    localparam logic [CW-1:0] DeskewMax = CW'(DESKEW);
    localparam logic [FW-1:0] FiltLast  = FW'(FILT - 1);

    // Glitch filter states
    localparam logic [0:0] StStable = 1'b0;
    localparam logic [0:0] StCount  = 1'b1;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [ZW-1:0] zraw;
    logic [OW-1:0] oraw;
    logic [ZW-1:0] zsync_q [SYNC_STAGES];
    logic [OW-1:0] osync_q [SYNC_STAGES];
    logic [ZW-1:0] zsync;
    logic [OW-1:0] osync;

    assign zraw = {bus_a_h, bus_c_h, bus_d_h,
                   bus_msyn_h, bus_ssyn_h, bus_bbsy_h, bus_sack_h, bus_hltrq_h};
    // Active-low grants and the init/power-low lines idle high through reset, so the
    // filters start from "asserted" and only release once real bus levels arrive.
    assign oraw = {bus_npg_l, bus_hltgr_l, bus_init_h, bus_aclo_h, bus_dclo_h};

    // Shift every raw line through SYNC_STAGES flops.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                zsync_q[i] <= '0;
                osync_q[i] <= '1;
            end
        end else begin
            zsync_q[0] <= zraw;
            osync_q[0] <= oraw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                zsync_q[i] <= zsync_q[i-1];
                osync_q[i] <= osync_q[i-1];
            end
        end
    end

    assign zsync = zsync_q[SYNC_STAGES-1];
    assign osync = osync_q[SYNC_STAGES-1];

    // A/C/D are not coherent cycle by cycle; consumers qualify them with del_*.
    assign a_in_h        = zsync[40:23];
    assign c_in_h        = zsync[22:21];
    assign d_in_h        = zsync[20:5];
    assign syn_msyn_in_h = zsync[4];
    assign syn_ssyn_in_h = zsync[3];
    assign bbsy_in_h     = zsync[2];
    assign sack_in_h     = zsync[1];
    assign hltrq_in_h    = zsync[0];
    assign npg_in_l      = osync[4];
    assign hltgr_in_l    = osync[3];

    // ------------------------------------------------------------------
    // Deskew: index 0 is MSYN, index 1 is SSYN; the two paths are independent.
    // ------------------------------------------------------------------
    logic [1:0]    strb;
    logic [CW-1:0] dsk_cnt_q [2];
    logic [CW-1:0] dsk_cnt_d [2];
    logic [1:0]    del_q;
    logic [1:0]    del_d;

    assign strb = {syn_ssyn_in_h, syn_msyn_in_h};

    // Count continuous high time, saturating at DESKEW; drop del as soon as syn drops.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dsk_cnt_d[i] = dsk_cnt_q[i];
            del_d[i]     = strb[i] && (dsk_cnt_q[i] == DeskewMax);
            if (!strb[i]) begin
                dsk_cnt_d[i] = '0;
            end else if (dsk_cnt_q[i] != DeskewMax) begin
                dsk_cnt_d[i] = dsk_cnt_q[i] + 1'b1;
            end
        end
    end

    // Deskew counter and del strobe registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            dsk_cnt_q[0] <= '0;
            dsk_cnt_q[1] <= '0;
            del_q        <= '0;
        end else begin
            dsk_cnt_q[0] <= dsk_cnt_d[0];
            dsk_cnt_q[1] <= dsk_cnt_d[1];
            del_q        <= del_d;
        end
    end

    assign del_msyn_in_h = del_q[0];
    assign del_ssyn_in_h = del_q[1];

    // ------------------------------------------------------------------
    // Runt MSYN counter
    // ------------------------------------------------------------------
    logic        msyn_prev_q;
    logic        runt;
    logic [15:0] runtcnt_q;
    logic [15:0] runtcnt_d;

    // A fall of syn_msyn is a runt when del_msyn never came up for that pulse; del_q
    // still reflects the last high cycle here, since it is one cycle behind syn.
    assign runt = msyn_prev_q && !syn_msyn_in_h && !del_q[0];

    // Saturating increment; a clear wins over a coincident runt.
    always_comb begin
        runtcnt_d = runtcnt_q;
        if (runtclr) begin
            runtcnt_d = '0;
        end else if (runt && (runtcnt_q != 16'hFFFF)) begin
            runtcnt_d = runtcnt_q + 16'd1;
        end
    end

    // Edge-detect history and runt count registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            msyn_prev_q <= 1'b0;
            runtcnt_q   <= '0;
        end else begin
            msyn_prev_q <= syn_msyn_in_h;
            runtcnt_q   <= runtcnt_d;
        end
    end

    assign runtcnt = runtcnt_q;

    // ------------------------------------------------------------------
    // Glitch filters: index 2 INIT, 1 ACLO, 0 DCLO.
    // ------------------------------------------------------------------
    logic [2:0]    ctl_sync;
    logic [0:0]    flt_st_q  [3];
    logic [0:0]    flt_st_d  [3];
    logic [FW-1:0] flt_cnt_q [3];
    logic [FW-1:0] flt_cnt_d [3];
    logic [2:0]    flt_out_q;
    logic [2:0]    flt_out_d;

    assign ctl_sync = osync[2:0];

    // Move the output only after FILT consecutive samples disagree with it.
    always_comb begin
        flt_out_d = flt_out_q;
        for (int i = 0; i < 3; i++) begin
            flt_st_d[i]  = flt_st_q[i];
            flt_cnt_d[i] = flt_cnt_q[i];
            case (flt_st_q[i])
                StStable: begin
                    if (ctl_sync[i] != flt_out_q[i]) begin
                        if (FiltLast == '0) begin
                            flt_out_d[i] = ctl_sync[i];
                        end else begin
                            flt_cnt_d[i] = FW'(1);
                            flt_st_d[i]  = StCount;
                        end
                    end
                end
                StCount: begin
                    if (ctl_sync[i] == flt_out_q[i]) begin
                        flt_cnt_d[i] = '0;
                        flt_st_d[i]  = StStable;
                    end else if (flt_cnt_q[i] == FiltLast) begin
                        flt_out_d[i] = ctl_sync[i];
                        flt_cnt_d[i] = '0;
                        flt_st_d[i]  = StStable;
                    end else begin
                        flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    flt_cnt_d[i] = '0;
                    flt_st_d[i]  = StStable;
                end
            endcase
        end
    end

    // Filter state, counters and outputs; outputs come out of reset asserted.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 3; i++) begin
                flt_st_q[i]  <= StStable;
                flt_cnt_q[i] <= '0;
            end
            flt_out_q <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                flt_st_q[i]  <= flt_st_d[i];
                flt_cnt_q[i] <= flt_cnt_d[i];
            end
            flt_out_q <= flt_out_d;
        end
    end

    assign init_in_h  = flt_out_q[2];
    assign ac_lo_in_h = flt_out_q[1];
    assign dc_lo_in_h = flt_out_q[0];

endmodule
